// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO issue controller: mul/div op codes,
// controller state encoding and op classification helpers.
package hilo_pkg;

  localparam logic [3:0] OP_MULT  = 4'b0101;
  localparam logic [3:0] OP_MULTU = 4'b0110;
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // True for any op that is handed to the arithmetic unit.
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // True for the divide ops, which are refused when the divisor is zero.
  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/hilo_wdog.sv
// Timeout watchdog for the HI/LO controller. Counts cycles while enabled,
// restarts on clear, and flags expiry in the TIMEOUT-th enabled cycle.
module hilo_wdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Expiry is seen during the last permitted cycle so the owner can act at that edge.
  assign expired = enable & (count == LAST);

  // Cycle counter: restart on clear, advance while enabled, hold once expired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hilo_ctrl.sv
// Issue-side controller for the multiply/divide unit. Issues MULT/MULTU/
// DIV/DIVU over a valid/ready channel, commits results into HI/LO, serves
// MFHI/MFLO/MTHI/MTLO and stalls the pipeline while an op is outstanding.
// Optional build macro: HILO_BYPASS_EN forwards du_hi/du_lo to rd_data in
// the du_done cycle of WAIT and releases the read stall for that cycle.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [3:0]       id_op,
  input  logic [WIDTH-1:0] id_a,
  input  logic [WIDTH-1:0] id_b,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             mfhi_re,
  input  logic             mflo_re,
  output logic [WIDTH-1:0] rd_data,
  input  logic             flush,
  output logic             stall,
  output logic             du_valid,
  output logic [3:0]       du_op,
  output logic [WIDTH-1:0] du_a,
  output logic [WIDTH-1:0] du_b,
  input  logic             du_ready,
  input  logic             du_done,
  input  logic [WIDTH-1:0] du_hi,
  input  logic [WIDTH-1:0] du_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             err
);

  state_t state;
  state_t state_next;

  logic op_req;
  logic div_by_zero;
  logic idle_wr;
  logic accept;
  logic commit;
  logic expired;
  logic timeout;
  logic wdog_clear;
  logic wdog_en;
  logic bypass;
  logic rd_req;
  logic rd_stall;

  assign op_req      = id_valid & is_muldiv(id_op);
  assign div_by_zero = is_div(id_op) & (id_b == '0);
  // IDLE without flush is the only window where HI/LO may be written by mt or an op accepted.
  assign idle_wr     = (state == ST_IDLE) & ~flush;
  assign accept      = idle_wr & op_req & ~div_by_zero;
  assign commit      = (state == ST_WAIT) & du_done;
  // A result arriving in the last allowed cycle wins over the timeout.
  assign timeout     = expired & ~du_done;

  assign wdog_en    = (state == ST_WAIT) | (state == ST_DRAIN);
  assign wdog_clear = (state_next != state) &
                      ((state_next == ST_WAIT) | (state_next == ST_DRAIN));

`ifdef HILO_BYPASS_EN
  assign bypass = commit;
`else
  assign bypass = 1'b0;
`endif

  hilo_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wdog_clear),
    .enable  (wdog_en),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; in WAIT a delivered result takes priority over timeout and flush.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (flush)         state_next = ST_IDLE;
        else if (du_ready) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (du_done)      state_next = ST_IDLE;
        else if (expired) state_next = ST_IDLE;
        else if (flush)   state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (du_done || expired) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Combinational outputs: busy, stall and read data (with optional result forwarding).
  always_comb begin
    busy     = (state != ST_IDLE);
    rd_req   = mfhi_re | mflo_re;
    rd_stall = rd_req & ~bypass;
    stall    = busy & (rd_stall | mthi_we | mtlo_we | op_req);
    rd_data  = '0;
    if (mfhi_re)      rd_data = bypass ? du_hi : hi;
    else if (mflo_re) rd_data = bypass ? du_lo : lo;
  end

  // Request channel: valid mirrors ISSUE; operands are captured only on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      du_valid <= 1'b0;
      du_op    <= '0;
      du_a     <= '0;
      du_b     <= '0;
    end else begin
      du_valid <= (state_next == ST_ISSUE);
      if (accept) begin
        du_op <= id_op;
        du_a  <= id_a;
        du_b  <= id_b;
      end
    end
  end

  // Architectural HI/LO: unit result on commit, otherwise mt writes while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      hi <= du_hi;
      lo <= du_lo;
    end else if (idle_wr) begin
      if (mthi_we) hi <= mt_data;
      if (mtlo_we) lo <= mt_data;
    end
  end

  // Sticky timeout error, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (timeout) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the controller.
module tb_hilo_ctrl;

  localparam int W       = 32;
  localparam int TIMEOUT = 64;
  localparam logic [3:0] C_MULT  = 4'b0101;
  localparam logic [3:0] C_MULTU = 4'b0110;
  localparam logic [3:0] C_DIV   = 4'b1011;
  localparam logic [3:0] C_DIVU  = 4'b0111;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         id_valid;
  logic [3:0]   id_op;
  logic [W-1:0] id_a, id_b;
  logic         mthi_we, mtlo_we;
  logic [W-1:0] mt_data;
  logic         mfhi_re, mflo_re;
  logic [W-1:0] rd_data;
  logic         flush;
  logic         stall;
  logic         du_valid;
  logic [3:0]   du_op;
  logic [W-1:0] du_a, du_b;
  logic         du_ready, du_done;
  logic [W-1:0] du_hi, du_lo;
  logic [W-1:0] hi, lo;
  logic         busy, err;

  int n_cmp = 0;
  int n_mis = 0;

  hilo_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op),
    .id_a(id_a), .id_b(id_b), .mthi_we(mthi_we), .mtlo_we(mtlo_we),
    .mt_data(mt_data), .mfhi_re(mfhi_re), .mflo_re(mflo_re), .rd_data(rd_data),
    .flush(flush), .stall(stall), .du_valid(du_valid), .du_op(du_op),
    .du_a(du_a), .du_b(du_b), .du_ready(du_ready), .du_done(du_done),
    .du_hi(du_hi), .du_lo(du_lo), .hi(hi), .lo(lo), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // An op is either waiting for acceptance (m_req), accepted and awaiting its
  // result (m_out), or squashed and awaiting a result to throw away (m_disc).
  logic         m_req, m_out, m_disc;
  int           m_age;
  logic [W-1:0] m_hi, m_lo, m_a, m_b;
  logic [3:0]   m_op;
  logic         m_err;

  function automatic logic md(input logic [3:0] op);
    return op == C_MULT || op == C_MULTU || op == C_DIV || op == C_DIVU;
  endfunction

  function automatic logic dv(input logic [3:0] op);
    return op == C_DIV || op == C_DIVU;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req <= 0; m_out <= 0; m_disc <= 0; m_age <= 0;
      m_hi <= '0; m_lo <= '0; m_a <= '0; m_b <= '0; m_op <= '0; m_err <= 0;
    end else if (m_req) begin
      if (flush) m_req <= 0;
      else if (du_ready) begin m_req <= 0; m_out <= 1; m_age <= 0; end
    end else if (m_out) begin
      if (du_done) begin m_hi <= du_hi; m_lo <= du_lo; m_out <= 0; end
      else if (m_age == TIMEOUT - 1) begin m_err <= 1; m_out <= 0; end
      else if (flush) begin m_out <= 0; m_disc <= 1; m_age <= 0; end
      else m_age <= m_age + 1;
    end else if (m_disc) begin
      if (du_done) m_disc <= 0;
      else if (m_age == TIMEOUT - 1) begin m_err <= 1; m_disc <= 0; end
      else m_age <= m_age + 1;
    end else if (!flush) begin
      if (mthi_we) m_hi <= mt_data;
      if (mtlo_we) m_lo <= mt_data;
      if (id_valid && md(id_op) && !(dv(id_op) && id_b == '0)) begin
        m_req <= 1; m_op <= id_op; m_a <= id_a; m_b <= id_b;
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    logic         e_busy, e_fwd, e_stall;
    logic [W-1:0] e_rd;
    e_busy = m_req | m_out | m_disc;
`ifdef HILO_BYPASS_EN
    e_fwd = m_out & du_done;
`else
    e_fwd = 1'b0;
`endif
    e_stall = e_busy & (((mfhi_re | mflo_re) & ~e_fwd) | mthi_we | mtlo_we | (id_valid & md(id_op)));
    e_rd = mfhi_re ? (e_fwd ? du_hi : m_hi) : (mflo_re ? (e_fwd ? du_lo : m_lo) : '0);
    check("m_busy", W'(busy), W'(e_busy));
    check("m_stall", W'(stall), W'(e_stall));
    check("m_rd_data", rd_data, e_rd);
    check("m_du_valid", W'(du_valid), W'(m_req));
    check("m_du_op", W'(du_op), W'(m_op));
    check("m_du_a", du_a, m_a);
    check("m_du_b", du_b, m_b);
    check("m_hi", hi, m_hi);
    check("m_lo", lo, m_lo);
    check("m_err", W'(err), W'(m_err));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_valid = 0; id_op = '0; id_a = '0; id_b = '0;
    mthi_we = 0; mtlo_we = 0; mt_data = '0; mfhi_re = 0; mflo_re = 0;
    flush = 0; du_ready = 0; du_done = 0; du_hi = '0; du_lo = '0;
  endtask

  // Issue op and complete the handshake immediately; ends in WAIT.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    id_valid = 1; id_op = op; id_a = a; id_b = b;
    tick();
    clear_in();
    du_ready = 1;
    tick();
    du_ready = 0;
  endtask

  initial begin
    clear_in();
    rst_n = 0;
    repeat (3) tick();
    check("rst_busy", W'(busy), '0);
    check("rst_du_valid", W'(du_valid), '0);
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    check("rst_err", W'(err), '0);
    check("rst_stall", W'(stall), '0);
    check("rst_rd_data", rd_data, '0);
    rst_n = 1;
    tick();

    // MULT with delayed ready then done -> hi=1, lo=2
    id_valid = 1; id_op = C_MULT; id_a = 32'd3; id_b = 32'd4;
    #1 check("t1_stall_idle", W'(stall), '0);
    tick();
    clear_in();
    #1 check("t1_du_valid", W'(du_valid), 1);
    check("t1_du_a", du_a, 32'd3);
    tick(); tick();
    du_ready = 1;
    tick();
    du_ready = 0;
    mfhi_re = 1;
    #1 check("t1_stall_mfhi", W'(stall), 1);
    mfhi_re = 0;
    #1 check("t1_stall_none", W'(stall), 0);
    repeat (4) tick();
    du_done = 1; du_hi = 32'h1; du_lo = 32'h2;
    #1 check("t1_busy_done", W'(busy), 1);
    tick();
    clear_in();
    #1 check("t1_hi", hi, 32'h1);
    check("t1_lo", lo, 32'h2);
    check("t1_busy_after", W'(busy), 0);

    // DIVU by zero is refused
    id_valid = 1; id_op = C_DIVU; id_a = 32'd5; id_b = 32'd0;
    tick();
    clear_in();
    #1 check("t2_du_valid", W'(du_valid), 0);
    check("t2_busy", W'(busy), 0);
    check("t2_hi", hi, 32'h1);

    // flush in WAIT, then the result is discarded
    issue(C_MULTU, 32'd7, 32'd9);
    flush = 1;
    tick();
    flush = 0;
    mfhi_re = 1;
    #1 check("t3_stall_drain", W'(stall), 1);
    check("t3_busy_drain", W'(busy), 1);
    mfhi_re = 0;
    du_done = 1; du_hi = 32'hDEAD; du_lo = 32'hBEEF;
    tick();
    clear_in();
    #1 check("t3_hi", hi, 32'h1);
    check("t3_lo", lo, 32'h2);
    check("t3_idle", W'(busy), 0);

    // MTHI while busy stalls until idle; op result lands first, mt after
    issue(C_DIV, 32'd100, 32'd7);
    mthi_we = 1; mt_data = 32'h55;
    #1 check("t4_stall_wait", W'(stall), 1);
    du_done = 1; du_hi = 32'h9; du_lo = 32'h8;
    #1 check("t4_stall_done", W'(stall), 1);
    tick();
    du_done = 0;
    #1 check("t4_stall_idle", W'(stall), 0);
    check("t4_hi_res", hi, 32'h9);
    tick();
    clear_in();
    #1 check("t4_hi_mt", hi, 32'h55);
    check("t4_lo", lo, 32'h8);

    // MFLO in the du_done cycle
    issue(C_MULT, 32'd2, 32'd3);
    mflo_re = 1; du_done = 1; du_hi = 32'h6; du_lo = 32'h7;
`ifdef HILO_BYPASS_EN
    #1 check("t5_byp_rd", rd_data, 32'h7);
    check("t5_byp_stall", W'(stall), 0);
`else
    #1 check("t5_stall", W'(stall), 1);
`endif
    tick();
    du_done = 0;
    #1 check("t5_rd", rd_data, 32'h7);
    check("t5_stall_after", W'(stall), 0);
    clear_in();

    // reset mid-operation; a later du_done is ignored
    issue(C_MULT, 32'd4, 32'd4);
    rst_n = 0;
    #1 check("t6_busy_rst", W'(busy), 0);
    check("t6_hi_rst", hi, 32'h0);
    rst_n = 1;
    du_done = 1; du_hi = 32'h77; du_lo = 32'h78;
    tick();
    clear_in();
    #1 check("t6_hi_ignored", hi, 32'h0);

    // timeout: no du_done for TIMEOUT cycles in WAIT
    issue(C_DIV, 32'd10, 32'd3);
    repeat (TIMEOUT - 1) tick();
    #1 check("t7_busy_last", W'(busy), 1);
    check("t7_err_before", W'(err), 0);
    tick();
    #1 check("t7_err", W'(err), 1);
    check("t7_idle", W'(busy), 0);
    check("t7_hi", hi, 32'h0);
    du_done = 1; du_hi = 32'hAA;
    tick();
    clear_in();
    #1 check("t7_hi_late", hi, 32'h0);
    rst_n = 0;
    #1 check("t7_err_rst", W'(err), 0);
    rst_n = 1;
    tick();

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int r;
      id_valid = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 5);
      case (r)
        0: id_op = C_MULT;
        1: id_op = C_MULTU;
        2: id_op = C_DIV;
        3: id_op = C_DIVU;
        default: id_op = 4'($urandom);
      endcase
      id_a     = $urandom;
      id_b     = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      mthi_we  = ($urandom_range(0, 7) == 0);
      mtlo_we  = ($urandom_range(0, 7) == 0);
      mt_data  = $urandom;
      mfhi_re  = ($urandom_range(0, 3) == 0);
      mflo_re  = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      du_ready = ($urandom_range(0, 1) == 0);
      du_done  = ($urandom_range(0, 5) == 0);
      du_hi    = $urandom;
      du_lo    = $urandom;
      rst_n    = ($urandom_range(0, 799) != 0);
      tick();
    end
    rst_n = 1;
    clear_in();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/hilo_ctrl.md
# hilo_ctrl

Issue-side controller for the multiply/divide unit: accepts MULT/MULTU/DIV/DIVU from the execute stage and hands operands to the arithmetic unit over a valid/ready request channel. It waits for the unit's done pulse and commits the result into the architectural HI/LO registers. It also serves MFHI/MFLO/MTHI/MTLO and drives the pipeline stall whenever an instruction touches HI/LO while an operation is outstanding.

## Interface
- WIDTH, 32, operand and HI/LO width
- TIMEOUT, 64, cycles in WAIT/DRAIN before the sticky error is raised
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  execute-stage instruction valid
- id_op  in  4  4'b0101 MULT, 4'b0110 MULTU, 4'b1011 DIV, 4'b0111 DIVU; other codes are not a mul/div op
- id_a, id_b  in  WIDTH  operands; id_a is the dividend, id_b the divisor
- mthi_we, mtlo_we  in  1  write HI / LO from mt_data
- mt_data  in  WIDTH  MTHI/MTLO data
- mfhi_re, mflo_re  in  1  read request
- rd_data  out  WIDTH  combinational read data
- flush  in  1  pipeline flush (exception or branch squash)
- stall  out  1  combinational stall to the pipeline
- du_valid  out  1  request valid (registered)
- du_op  out  4  registered op
- du_a, du_b  out  WIDTH  registered operands
- du_ready  in  1  unit accepts the request
- du_done  in  1  one-cycle result pulse
- du_hi, du_lo  in  WIDTH  unit result; du_lo is the product low word or quotient, du_hi the product high word or remainder
- hi, lo  out  WIDTH  architectural HI/LO
- busy  out  1  state != IDLE
- err  out  1  sticky timeout flag

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE, id_valid with a mul/div op:
  - Capture du_op/du_a/du_b and go to ISSUE.
  - Exception: DIV/DIVU with id_b == 0 is not issued. HI/LO are unchanged and the state stays IDLE.
- ISSUE: hold du_valid=1 with stable operands. On du_valid & du_ready, go to WAIT.
- WAIT: on du_done, write hi<=du_hi and lo<=du_lo, then go to IDLE.
- flush:
  - In ISSUE: drop du_valid and return to IDLE without a handshake.
  - In WAIT: go to DRAIN.
  - In IDLE: suppresses a same-cycle issue and mt write.
- DRAIN: discard du_done without touching HI/LO, then go to IDLE.
- Register writes: mthi_we/mtlo_we write in IDLE only. An mt in the same cycle as an accepted op writes first; the op result overwrites later.
- Stall equation: stall = busy & (mfhi_re | mflo_re | mthi_we | mtlo_we | (id_valid & mul/div op)).
- Read data: rd_data = hi if mfhi_re, else lo if mflo_re, else 0.
- Timeout counter:
  - Clears on entry to WAIT or DRAIN and counts each cycle there.
  - Reaching TIMEOUT sets err, forces IDLE and leaves HI/LO unchanged.
  - err clears only on reset.
- du_done outside WAIT/DRAIN is ignored.
- Widths: all results are taken as delivered by the unit. No sign handling happens here.

## Timing
- Reset values: hi=0, lo=0, du_valid=0, du_op=0, du_a=0, du_b=0, busy=0, err=0, state IDLE. Combinational outputs: stall=0, rd_data=0 when no read is requested.
- Issue: op accepted at edge N, so du_valid=1 from N+1.
- Handshake completes at the first edge with du_ready=1.
- HI/LO update at the edge sampling du_done and are visible the cycle after.
- A dependent MFHI issued in the du_done cycle stalls one cycle and reads the new value next cycle.
- Back-to-back ops: a new op is accepted in the cycle after commit, when the state is IDLE.
- Reset mid-operation: immediate return to reset values. A later du_done is ignored, since the state is IDLE.

## Configuration
- HILO_BYPASS_EN defined:
  - In WAIT with du_done=1, mfhi_re/mflo_re return du_hi/du_lo on rd_data.
  - stall is deasserted for the read in that cycle.
  - Never bypasses in DRAIN.
- Undefined: the behaviour described under Timing (one stall cycle, then read from the register).

## Structure
- hilo_pkg holds the op code constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the state enum, and an is_muldiv(op) function.
- One sub-module, hilo_wdog: the timeout counter, with clear/enable in and expired out.

## Test plan
- MULT issue, du_ready after 2 cycles, du_done 5 cycles later with du_hi=32'h1, du_lo=32'h2 -> hi=1, lo=2 on the next cycle; busy high throughout; stall only on HI/LO accesses.
- DIVU with id_b=0 -> no du_valid, hi/lo unchanged, busy stays 0.
- flush in WAIT, then du_done with du_hi=32'hDEAD -> hi unchanged; IDLE after du_done; MFHI during DRAIN stalls.
- MTHI 32'h55 while busy -> stall=1 until IDLE, then hi=32'h55 is written.
- MFLO in the du_done cycle (du_lo=32'h7):
  - With HILO_BYPASS_EN: rd_data=7, stall=0.
  - Without: stall=1 for one cycle, then rd_data=7.
- No du_done for TIMEOUT=64 cycles in WAIT -> err=1, state IDLE, hi/lo unchanged; rst_n low -> err=0.
